sram_bus_bridge: RTL

//  Downstream of the cpu core's memory port. Consumes mCLK/mADDR/mDIN/mWE/mOEN.

---
 rtl/sram_bridge_pkg.sv | 31 +++
 rtl/mclk_edge_det.sv | 22 ++
 rtl/sram_bus_bridge.sv | 139 +++++++++++++
 3 files changed

// File: rtl/sram_bridge_pkg.sv
// Shared types for the cpu-memory-port to async SRAM bridge.
package sram_bridge_pkg;

  // Access sequencer states
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2,
    ST_HOLD   = 2'd3
  } state_e;

  // Decoded cpu request
  typedef enum logic [1:0] {
    REQ_NONE  = 2'd0,
    REQ_READ  = 2'd1,
    REQ_WRITE = 2'd2
  } req_e;

  // Write wins over read when both strobes are asserted
  function automatic req_e decode_req(input logic we, input logic oen);
    req_e r;
    r = REQ_NONE;
    if (we) begin
      r = REQ_WRITE;
    end else if (!oen) begin
      r = REQ_READ;
    end
    return r;
  endfunction

endpackage

// File: rtl/mclk_edge_det.sv
// Rising-edge detector for the cpu memory strobe, synchronous to the system clock.
module mclk_edge_det (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic mclk_i,
  output logic start_c_o
);

  logic mclk_q;

  // Previous mCLK level; resets high so a strobe already high at release is not an edge
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      mclk_q <= 1'b1;
    end else begin
      mclk_q <= mclk_i;
    end
  end

  assign start_c_o = mclk_i & ~mclk_q;

endmodule

// File: rtl/sram_bus_bridge.sv
// Runs one timed async-SRAM access per mCLK rising edge, with ROM write protection.
module sram_bus_bridge
  import sram_bridge_pkg::*;
#(
  parameter int unsigned          ADDR_W      = 16,
  parameter int unsigned          DATA_W      = 8,
  parameter int unsigned          WAIT_STATES = 2,
  parameter logic [ADDR_W-1:0]    ROM_BASE    = 16'hE000,
  parameter logic [DATA_W-1:0]    RESET_DOUT  = 8'hEA
) (
  input  logic              GlobalClock,
  input  logic              nReset,
  input  logic              mCLK,
  input  logic [ADDR_W-1:0] mADDR,
  input  logic [DATA_W-1:0] mDIN,
  input  logic              mWE,
  input  logic              mOEN,
  output logic [DATA_W-1:0] mDOUT,
  output logic              busy,
  output logic              overrun,
  output logic              wp_err,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [DATA_W-1:0] sram_dq_o,
  output logic              sram_dq_oe,
  input  logic [DATA_W-1:0] sram_dq_i,
  output logic              sram_ce_n,
  output logic              sram_oe_n,
  output logic              sram_we_n
);

  localparam int unsigned CNT_W = $clog2(WAIT_STATES + 1);

  logic              start_c;
  req_e              req_c;
  logic              rom_hit_c;

  state_e            state_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              is_wr_q;
  logic [DATA_W-1:0] mdout_q;
  logic              busy_q;
  logic              overrun_q;
  logic              wp_err_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] dq_o_q;
  logic              dq_oe_q;
  logic              ce_n_q;
  logic              oe_n_q;
  logic              we_n_q;

  mclk_edge_det u_edge (
    .clk_i     (GlobalClock),
    .rst_ni    (nReset),
    .mclk_i    (mCLK),
    .start_c_o (start_c)
  );

  assign req_c     = decode_req(mWE, mOEN);
  assign rom_hit_c = (mADDR >= ROM_BASE);

  // Access sequencer with registered SRAM strobes, capture registers and sticky flags
  always_ff @(posedge GlobalClock or negedge nReset) begin
    if (!nReset) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      is_wr_q   <= 1'b0;
      mdout_q   <= RESET_DOUT;
      busy_q    <= 1'b0;
      overrun_q <= 1'b0;
      wp_err_q  <= 1'b0;
      addr_q    <= '0;
      dq_o_q    <= '0;
      dq_oe_q   <= 1'b0;
      ce_n_q    <= 1'b1;
      oe_n_q    <= 1'b1;
      we_n_q    <= 1'b1;
    end else begin
      if (start_c && (state_q != ST_IDLE)) begin
        overrun_q <= 1'b1;
      end
      case (state_q)
        ST_IDLE: begin
          if (start_c) begin
            addr_q <= mADDR;
            dq_o_q <= mDIN;
            if ((req_c == REQ_WRITE) && rom_hit_c) begin
              wp_err_q <= 1'b1;
            end else if (req_c != REQ_NONE) begin
              state_q <= ST_SETUP;
              busy_q  <= 1'b1;
              ce_n_q  <= 1'b0;
              is_wr_q <= (req_c == REQ_WRITE);
              dq_oe_q <= (req_c == REQ_WRITE);
            end
          end
        end
        ST_SETUP: begin
          state_q <= ST_ACCESS;
          cnt_q   <= CNT_W'(WAIT_STATES);
          oe_n_q  <= is_wr_q;
          we_n_q  <= ~is_wr_q;
        end
        ST_ACCESS: begin
          if (cnt_q == CNT_W'(1)) begin
            state_q <= ST_HOLD;
            oe_n_q  <= 1'b1;
            we_n_q  <= 1'b1;
            if (!is_wr_q) begin
              mdout_q <= sram_dq_i;
            end
          end else begin
            cnt_q <= cnt_q - CNT_W'(1);
          end
        end
        ST_HOLD: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
          ce_n_q  <= 1'b1;
          dq_oe_q <= 1'b0;
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign mDOUT      = mdout_q;
  assign busy       = busy_q;
  assign overrun    = overrun_q;
  assign wp_err     = wp_err_q;
  assign sram_addr  = addr_q;
  assign sram_dq_o  = dq_o_q;
  assign sram_dq_oe = dq_oe_q;
  assign sram_ce_n  = ce_n_q;
  assign sram_oe_n  = oe_n_q;
  assign sram_we_n  = we_n_q;

endmodule
